// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports, the data-memory port and busy for dmem_arbiter.
// DMEM_ARB_LOCK_EN adds lock1 on the host port.
interface dmem_arbiter_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 16
);
    logic          req0;
    logic          wr0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          gnt0;
    logic          rvalid0;
    logic [DW-1:0] rdata0;

    logic          req1;
    logic          wr1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          gnt1;
    logic          rvalid1;
    logic [DW-1:0] rdata1;
`ifdef DMEM_ARB_LOCK_EN
    logic          lock1;
`endif

    logic [AW-1:0] D_Addr;
    logic          D_wr;
    logic [DW-1:0] D_wdata;
    logic [DW-1:0] D_rdata;
    logic          busy;

    // Arbiter side
    modport slave (
`ifdef DMEM_ARB_LOCK_EN
        input  lock1,
`endif
        input  req0, wr0, addr0, wdata0,
        output gnt0, rvalid0, rdata0,
        input  req1, wr1, addr1, wdata1,
        output gnt1, rvalid1, rdata1,
        output D_Addr, D_wr, D_wdata,
        input  D_rdata,
        output busy
    );

    // Requester / memory side
    modport master (
`ifdef DMEM_ARB_LOCK_EN
        output lock1,
`endif
        output req0, wr0, addr0, wdata0,
        input  gnt0, rvalid0, rdata0,
        output req1, wr1, addr1, wdata1,
        input  gnt1, rvalid1, rdata1,
        input  D_Addr, D_wr, D_wdata,
        output D_rdata,
        input  busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a synchronous single-port data memory between CPU (port 0) and host (port 1).
// Optional DMEM_ARB_LOCK_EN: lock1 gives the host sticky priority for atomic multi-word sequences.
module dmem_arbiter #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 16
) (
    input  logic          Clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          owner_q, owner_d;
    logic          wr_q, wr_d;
    logic          last_owner_q, last_owner_d;
    logic [AW-1:0] d_addr_q, d_addr_d;
    logic [DW-1:0] d_wdata_q, d_wdata_d;
    logic          d_wr_q, d_wr_d;
    logic          rvalid0_q, rvalid0_d;
    logic          rvalid1_q, rvalid1_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;

    logic          req_any_c;
    logic          win_c;
    logic          lock_hold_c;
    logic          gnt0_c;
    logic          gnt1_c;

`ifdef DMEM_ARB_LOCK_EN
    logic          lock_q, lock_d;
    assign lock_hold_c = lock_q & bus.req1;
`else
    assign lock_hold_c = 1'b0;
`endif

    // Winner selection: lock first, then alternate on a tie, else the lone requester
    always_comb begin
        req_any_c = bus.req0 | bus.req1;
        if (lock_hold_c) begin
            win_c = 1'b1;
        end else if (bus.req0 && bus.req1) begin
            win_c = ~last_owner_q;
        end else begin
            win_c = bus.req1;
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (req_any_c) state_d = ST_ACCESS;
            ST_ACCESS: state_d = wr_q ? ST_IDLE : ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        gnt0_c       = 1'b0;
        gnt1_c       = 1'b0;
        owner_d      = owner_q;
        wr_d         = wr_q;
        last_owner_d = last_owner_q;
        d_addr_d     = d_addr_q;
        d_wdata_d    = d_wdata_q;
        d_wr_d       = 1'b0;
        rvalid0_d    = 1'b0;
        rvalid1_d    = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
`ifdef DMEM_ARB_LOCK_EN
        lock_d       = lock_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_any_c) begin
                    gnt0_c       = ~win_c;
                    gnt1_c       = win_c;
                    owner_d      = win_c;
                    last_owner_d = win_c;
                    wr_d         = win_c ? bus.wr1    : bus.wr0;
                    d_addr_d     = win_c ? bus.addr1  : bus.addr0;
                    d_wdata_d    = win_c ? bus.wdata1 : bus.wdata0;
                    d_wr_d       = win_c ? bus.wr1    : bus.wr0;
                end
`ifdef DMEM_ARB_LOCK_EN
                if (!bus.req1) begin
                    lock_d = 1'b0;
                end
                if (req_any_c && win_c) begin
                    lock_d = bus.lock1;
                end
`endif
            end
            // Reads raise rvalid for the RESP cycle, when the memory data arrives
            ST_ACCESS: begin
                rvalid0_d = ~wr_q & ~owner_q;
                rvalid1_d = ~wr_q & owner_q;
            end
            ST_RESP: begin
                if (owner_q) begin
                    rdata1_d = bus.D_rdata;
                end else begin
                    rdata0_d = bus.D_rdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            owner_q      <= 1'b0;
            wr_q         <= 1'b0;
            last_owner_q <= 1'b1;
            d_addr_q     <= '0;
            d_wdata_q    <= '0;
            d_wr_q       <= 1'b0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
`ifdef DMEM_ARB_LOCK_EN
            lock_q       <= 1'b0;
`endif
        end else begin
            owner_q      <= owner_d;
            wr_q         <= wr_d;
            last_owner_q <= last_owner_d;
            d_addr_q     <= d_addr_d;
            d_wdata_q    <= d_wdata_d;
            d_wr_q       <= d_wr_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
`ifdef DMEM_ARB_LOCK_EN
            lock_q       <= lock_d;
`endif
        end
    end

    assign bus.gnt0    = gnt0_c & ~reset;
    assign bus.gnt1    = gnt1_c & ~reset;
    assign bus.rvalid0 = rvalid0_q;
    assign bus.rvalid1 = rvalid1_q;
    // The response register loads at the end of RESP; bypass so data is visible with rvalid
    assign bus.rdata0  = (state_q == ST_RESP && !owner_q) ? bus.D_rdata : rdata0_q;
    assign bus.rdata1  = (state_q == ST_RESP &&  owner_q) ? bus.D_rdata : rdata1_q;
    assign bus.D_Addr  = d_addr_q;
    assign bus.D_wr    = d_wr_q;
    assign bus.D_wdata = d_wdata_q;
    assign bus.busy    = (state_q != ST_IDLE);
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table for basic write/read, plus round-robin, reset-abort,
// RESP-cycle request and (with DMEM_ARB_LOCK_EN) host-lock sequences against a 256x16 memory model.
module tb_dmem_arbiter;
    logic clk;
    logic rst;
    logic mem_load;
    int   ntotal;
    int   nbad;

    dmem_arbiter_if #(.AW(8), .DW(16)) bus ();

    dmem_arbiter #(.AW(8), .DW(16)) dut (
        .Clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem [256];

    // Synchronous memory model, preloaded with A000|addr
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'hA000 | 16'(i);
        end else begin
            if (bus.D_wr) mem[bus.D_Addr] <= bus.D_wdata;
            bus.D_rdata <= mem[bus.D_Addr];
        end
    end

    typedef struct {
        logic        req0;
        logic        wr0;
        logic [7:0]  addr0;
        logic [15:0] wdata0;
        logic        req1;
        logic        wr1;
        logic [7:0]  addr1;
        logic [15:0] wdata1;
        logic        gnt0;
        logic        gnt1;
        logic        d_wr;
        logic [7:0]  d_addr;
        logic [15:0] d_wdata;
        logic        rvalid0;
        logic        rvalid1;
        logic [15:0] rdata0;
        logic [15:0] rdata1;
        logic        busy;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 10) begin
            tick();
            n++;
        end
        if (bus.busy) begin
            ntotal++;
            nbad++;
            $display("FAIL wait_idle: busy got 1 want 0 after 10 cycles");
        end
    endtask

    int cnt0;
    int cnt1;
    int exp_port;
    logic [7:0] a0;
    logic [7:0] a1;

    initial begin
        ntotal = 0;
        nbad   = 0;
        rst      = 1'b1;
        mem_load = 1'b1;
        bus.req0 = 1'b1; bus.wr0 = 1'b0; bus.addr0 = 8'h00; bus.wdata0 = 16'h0000;
        bus.req1 = 1'b1; bus.wr1 = 1'b0; bus.addr1 = 8'h00; bus.wdata1 = 16'h0000;
`ifdef DMEM_ARB_LOCK_EN
        bus.lock1 = 1'b0;
`endif

        //            req0 wr0   addr0  wdata0      req1  wr1   addr1  wdata1      gnt0  gnt1  d_wr  d_addr d_wdata     rv0   rv1   rdata0      rdata1      busy
        vecs[0] = '{1'b1, 1'b1, 8'h12, 16'hBEEF, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 8'hFF, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h12, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 8'hFF, 16'h0000, 1'b1, 1'b0, 8'h12, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h12, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 8'hFF, 16'h0000, 1'b0, 1'b0, 8'hAA, 16'h5555, 1'b0, 1'b0, 1'b0, 8'h12, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 8'hFF, 16'h0000, 1'b0, 1'b0, 8'hAA, 16'h5555, 1'b0, 1'b0, 1'b0, 8'h12, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'hBEEF, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 8'hFF, 16'h0000, 1'b0, 1'b0, 8'hAA, 16'h5555, 1'b0, 1'b0, 1'b0, 8'h12, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'hBEEF, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        mem_load = 1'b0;

        // Reset values, with both requests high to show gnt is forced low
        @(negedge clk);
        chk("rst.gnt0",    32'(bus.gnt0),    32'h0);
        chk("rst.gnt1",    32'(bus.gnt1),    32'h0);
        chk("rst.d_wr",    32'(bus.D_wr),    32'h0);
        chk("rst.d_addr",  32'(bus.D_Addr),  32'h0);
        chk("rst.d_wdata", 32'(bus.D_wdata), 32'h0);
        chk("rst.busy",    32'(bus.busy),    32'h0);
        chk("rst.rvalid0", 32'(bus.rvalid0), 32'h0);
        chk("rst.rvalid1", 32'(bus.rvalid1), 32'h0);
        chk("rst.rdata0",  32'(bus.rdata0),  32'h0);
        chk("rst.rdata1",  32'(bus.rdata1),  32'h0);
        tick();
        rst = 1'b0;

        // Port 0 write then port 1 read-back of the same word
        for (int i = 0; i < 6; i++) begin
            bus.req0 = vecs[i].req0; bus.wr0 = vecs[i].wr0; bus.addr0 = vecs[i].addr0; bus.wdata0 = vecs[i].wdata0;
            bus.req1 = vecs[i].req1; bus.wr1 = vecs[i].wr1; bus.addr1 = vecs[i].addr1; bus.wdata1 = vecs[i].wdata1;
            @(negedge clk);
            chk($sformatf("v%0d.gnt0", i),    32'(bus.gnt0),    32'(vecs[i].gnt0));
            chk($sformatf("v%0d.gnt1", i),    32'(bus.gnt1),    32'(vecs[i].gnt1));
            chk($sformatf("v%0d.d_wr", i),    32'(bus.D_wr),    32'(vecs[i].d_wr));
            chk($sformatf("v%0d.d_addr", i),  32'(bus.D_Addr),  32'(vecs[i].d_addr));
            chk($sformatf("v%0d.d_wdata", i), 32'(bus.D_wdata), 32'(vecs[i].d_wdata));
            chk($sformatf("v%0d.rvalid0", i), 32'(bus.rvalid0), 32'(vecs[i].rvalid0));
            chk($sformatf("v%0d.rvalid1", i), 32'(bus.rvalid1), 32'(vecs[i].rvalid1));
            chk($sformatf("v%0d.rdata0", i),  32'(bus.rdata0),  32'(vecs[i].rdata0));
            chk($sformatf("v%0d.rdata1", i),  32'(bus.rdata1),  32'(vecs[i].rdata1));
            chk($sformatf("v%0d.busy", i),    32'(bus.busy),    32'(vecs[i].busy));
            tick();
        end

        // Both ports continuously requesting reads: grants alternate starting with port 0
        cnt0 = 0;
        cnt1 = 0;
        bus.req0 = 1'b1; bus.wr0 = 1'b0; bus.wdata0 = 16'h1111;
        bus.req1 = 1'b1; bus.wr1 = 1'b0; bus.wdata1 = 16'h2222;
        for (int k = 0; k < 8; k++) begin
            exp_port = k % 2;
            a0 = 8'h20 + 8'(k);
            a1 = 8'h30 + 8'(k);
            bus.addr0 = a0;
            bus.addr1 = a1;
            @(negedge clk);
            chk($sformatf("rr%0d.gnt0", k), 32'(bus.gnt0), 32'(exp_port == 0));
            chk($sformatf("rr%0d.gnt1", k), 32'(bus.gnt1), 32'(exp_port == 1));
            cnt0 += int'(bus.rvalid0);
            cnt1 += int'(bus.rvalid1);
            tick();
            @(negedge clk);
            chk($sformatf("rr%0d.acc_gnt", k), 32'({bus.gnt0, bus.gnt1}), 32'h0);
            chk($sformatf("rr%0d.d_addr", k), 32'(bus.D_Addr), 32'(exp_port == 1 ? a1 : a0));
            chk($sformatf("rr%0d.d_wr", k), 32'(bus.D_wr), 32'h0);
            cnt0 += int'(bus.rvalid0);
            cnt1 += int'(bus.rvalid1);
            tick();
            @(negedge clk);
            chk($sformatf("rr%0d.resp_gnt", k), 32'({bus.gnt0, bus.gnt1}), 32'h0);
            if (exp_port == 1) chk($sformatf("rr%0d.rdata1", k), 32'(bus.rdata1), 32'(16'hA000 | 16'(a1)));
            else               chk($sformatf("rr%0d.rdata0", k), 32'(bus.rdata0), 32'(16'hA000 | 16'(a0)));
            cnt0 += int'(bus.rvalid0);
            cnt1 += int'(bus.rvalid1);
            tick();
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        chk("rr.cnt0", 32'(cnt0), 32'd4);
        chk("rr.cnt1", 32'(cnt1), 32'd4);

        // Reset asserted during ACCESS of a write to 8'h40 aborts it
        bus.req0 = 1'b1; bus.wr0 = 1'b1; bus.addr0 = 8'h40; bus.wdata0 = 16'h4444;
        @(negedge clk);
        chk("ra.gnt0", 32'(bus.gnt0), 32'h1);
        tick();
        bus.req0 = 1'b0; bus.wr0 = 1'b0;
        #2;
        chk("ra.acc_d_wr", 32'(bus.D_wr), 32'h1);
        chk("ra.acc_addr", 32'(bus.D_Addr), 32'h40);
        rst = 1'b1;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        #1;
        chk("ra.d_wr",    32'(bus.D_wr),    32'h0);
        chk("ra.d_addr",  32'(bus.D_Addr),  32'h0);
        chk("ra.d_wdata", 32'(bus.D_wdata), 32'h0);
        chk("ra.busy",    32'(bus.busy),    32'h0);
        chk("ra.gnt",     32'({bus.gnt0, bus.gnt1}), 32'h0);
        chk("ra.rdata0",  32'(bus.rdata0),  32'h0);
        chk("ra.rdata1",  32'(bus.rdata1),  32'h0);
        chk("ra.rvalid",  32'({bus.rvalid0, bus.rvalid1}), 32'h0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("ra.tie_gnt0", 32'(bus.gnt0), 32'h1);
        chk("ra.tie_gnt1", 32'(bus.gnt1), 32'h0);
        chk("ra.mem40",    32'(mem[8'h40]), 32'hA040);
        tick();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        wait_idle();

        // req0 pulsed only during RESP of a port 1 read is ignored
        bus.req1 = 1'b1; bus.wr1 = 1'b0; bus.addr1 = 8'h55;
        @(negedge clk);
        chk("rp.gnt1", 32'(bus.gnt1), 32'h1);
        tick();
        bus.req1 = 1'b0;
        tick();
        bus.req0 = 1'b1; bus.wr0 = 1'b1; bus.addr0 = 8'h66; bus.wdata0 = 16'h6666;
        @(negedge clk);
        chk("rp.resp_gnt0", 32'(bus.gnt0), 32'h0);
        chk("rp.rvalid1",   32'(bus.rvalid1), 32'h1);
        chk("rp.rdata1",    32'(bus.rdata1), 32'hA055);
        tick();
        bus.req0 = 1'b0;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            chk($sformatf("rp.idle%0d_gnt0", j), 32'(bus.gnt0), 32'h0);
            chk($sformatf("rp.idle%0d_d_wr", j), 32'(bus.D_wr), 32'h0);
            chk($sformatf("rp.idle%0d_busy", j), 32'(bus.busy), 32'h0);
            tick();
        end
        chk("rp.mem66", 32'(mem[8'h66]), 32'hA066);
        bus.wr0 = 1'b0;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        @(negedge clk);
        chk("rp.tie_gnt0", 32'(bus.gnt0), 32'h1);
        chk("rp.tie_gnt1", 32'(bus.gnt1), 32'h0);
        tick();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        wait_idle();

`ifdef DMEM_ARB_LOCK_EN
        // Host locked writes keep priority over a held req0 until lock1=0
        bus.req0 = 1'b1; bus.wr0 = 1'b1; bus.addr0 = 8'h77; bus.wdata0 = 16'h7777;
        bus.req1 = 1'b1; bus.wr1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.addr1  = 8'h70 + 8'(i);
            bus.wdata1 = 16'h7000 + 16'(i);
            bus.lock1  = (i < 2);
            @(negedge clk);
            chk($sformatf("lk%0d.gnt1", i), 32'(bus.gnt1), 32'h1);
            chk($sformatf("lk%0d.gnt0", i), 32'(bus.gnt0), 32'h0);
            tick();
            @(negedge clk);
            chk($sformatf("lk%0d.d_wr", i), 32'(bus.D_wr), 32'h1);
            chk($sformatf("lk%0d.d_addr", i), 32'(bus.D_Addr), 32'(8'h70 + 8'(i)));
            tick();
        end
        @(negedge clk);
        chk("lk.after_gnt0", 32'(bus.gnt0), 32'h1);
        chk("lk.after_gnt1", 32'(bus.gnt1), 32'h0);
        tick();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.lock1 = 1'b0;
        wait_idle();
        tick();
        for (int i = 0; i < 3; i++) chk($sformatf("lk.mem%0d", i), 32'(mem[8'h70 + 8'(i)]), 32'(16'h7000 + 16'(i)));
        chk("lk.mem77", 32'(mem[8'h77]), 32'h7777);
`endif

        $display("test done: total=%0d bad=%0d", ntotal, nbad);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory (256 x 16) between two requesters: port 0 = CPU control unit, port 1 = host/loader (program/data preload, debug readback).
- Sits between the requesters and the data memory; owns D_Addr/D_wr/D_wdata.
- Round-robin arbitration with a req/gnt handshake; reads return through a registered rvalid/rdata response.
- Memory is synchronous: read data is valid the cycle after the address is presented.

Parameters:
AW, 8, address width (D_Addr)
DW, 16, data width

Ports:
Clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
req0  input  1  CPU access request; held until gnt0
wr0  input  1  CPU 1=write, 0=read
addr0  input  AW  CPU address
wdata0  input  DW  CPU write data
gnt0  output  1  CPU request accepted this cycle
rvalid0  output  1  CPU read data valid (1-cycle pulse)
rdata0  output  DW  CPU read data
req1, wr1, addr1, wdata1, gnt1, rvalid1, rdata1  same as port 0, for host
D_Addr  output  AW  memory address
D_wr  output  1  memory write enable
D_wdata  output  DW  memory write data
D_rdata  input  DW  memory read data (1-cycle latency)
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, immediate): state=IDLE; gnt0/1=0; rvalid0/1=0; rdata0/1=0; D_Addr=0; D_wr=0; D_wdata=0; last_owner=1, so port 0 wins the first tie.
- gnt outputs are forced 0 while reset is high.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - Winner is chosen combinationally from req0/req1.
  - If only one port requests, it wins.
  - If both request, the port != last_owner wins.
  - gnt_winner=1 in this cycle only; the req&gnt cycle is the handshake.
  - On the clock edge: latch owner, wr, addr, wdata into internal registers; last_owner<=winner; go to ACCESS.
  - If there is no request, stay in IDLE. All memory outputs stay inactive: D_wr=0; D_Addr/D_wdata hold their previous values.
- ACCESS:
  - D_Addr=latched addr and D_wdata=latched wdata, both registered outputs.
  - D_wr=latched wr for exactly this one cycle.
  - Write: next state is IDLE. Read: next state is RESP.
  - gnt0 and gnt1 are both 0.
- RESP:
  - rdata_owner<=D_rdata, registered; rvalid_owner=1 for one cycle.
  - Next state is IDLE.
  - The non-owner's rdata holds its last value.
- Latency from the handshake edge:
  - Write: the memory write occurs 1 cycle later.
  - Read: rvalid is high 2 cycles later.
- Throughput: writes every 2 cycles; reads every 3 cycles.
- Requesters may change addr/wr/wdata freely after their gnt cycle. The arbiter uses only latched values.
- Dropping req before gnt is legal: no transaction occurs and last_owner is unchanged.
- req is ignored in ACCESS and RESP. A requester holds req and waits for IDLE.
- No starvation: with both ports continuously requesting, grants alternate 0,1,0,1...
- Reset asserted in ACCESS or RESP:
  - The transaction is aborted and D_wr drops immediately.
  - No rvalid is issued.
  - After reset release, the next tie goes to port 0.
- Address covers the full 2^AW space; there is no out-of-range case.

Optional Feature:
- Macro: DMEM_ARB_LOCK_EN.
- Defined:
  - Adds input lock1 (1 bit), sampled with the port-1 handshake.
  - If a granted port-1 access had lock1=1, port 1 holds absolute priority in following IDLE cycles while req1=1. This gives atomic multi-word host loads.
  - The lock clears when a port-1 access is granted with lock1=0, when req1=0 in IDLE, or on reset.
- Not defined: the lock1 port does not exist and arbitration is pure round-robin.

Test Plan:
- Reset, then port 0 write addr0=8'h12, wdata0=16'hBEEF: gnt0 pulses in the handshake cycle; next cycle D_Addr=8'h12, D_wdata=16'hBEEF, D_wr=1 for 1 cycle; busy=1 for that cycle only.
- Port 1 read addr1=8'h12, memory model returns 16'hBEEF: gnt1 in cycle N, D_Addr=8'h12 with D_wr=0 in N+1, rvalid1=1 and rdata1=16'hBEEF in N+2; rvalid0 stays 0.
- req0 and req1 both held high for 8 grants, all reads: grant order is 0,1,0,1,0,1,0,1; each port gets 4 rvalid pulses; gnt never high outside IDLE.
- Assert reset during ACCESS of a write to 8'h40: D_wr falls immediately; all outputs return to reset values; after release a tie goes to port 0.
- req0 raised for 1 cycle while in RESP, then dropped: no gnt0 issued, no memory activity, last_owner unchanged.
- DMEM_ARB_LOCK_EN defined: port 1 issues 3 writes with lock1=1,1,0 while req0 is held high; port 1 gets all 3 consecutive grants, then port 0 is granted next.
